// File: rtl/fifo_router_pkg.sv
// Shared types and widths for the FIFO drain router.
package fifo_router_pkg;

    localparam int unsigned SRC_W  = 8;
    localparam int unsigned DST_W  = 8;
    localparam int unsigned DATA_W = 32;

    // Drain FSM: IDLE waits for data, WAIT absorbs the read latency, SEND holds the word.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        SEND = 2'd2
    } state_e;

    // One word as presented by the upstream FIFO.
    typedef struct packed {
        logic [SRC_W-1:0]  src;
        logic [DST_W-1:0]  dst;
        logic [DATA_W-1:0] data;
    } word_t;

    // True when a destination tag addresses an existing output port.
    function automatic logic dst_in_range(input logic [DST_W-1:0] dst, input int unsigned num_ports);
        return (32'(dst) < num_ports);
    endfunction

endpackage

// File: rtl/router_sat_cnt.sv
// Saturating event counter: sticks at all-ones instead of wrapping.
module router_sat_cnt #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstp,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_cnt;

    // Count one event per cycle until every bit is set.
    always_ff @(posedge clk or posedge rstp) begin
        if (rstp) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign count = r_cnt;

endmodule

// File: rtl/fifo_drain_router.sv
// Drains an upstream FIFO (one-cycle read latency) and routes each word to the
// output port named by its destination tag; out-of-range tags are dropped.
// Optional statistics counters are built only with FIFO_ROUTER_STATS_EN defined.
module fifo_drain_router
    import fifo_router_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                   clk,
    input  logic                   rstp,
    input  logic [SRC_W-1:0]       src_out,
    input  logic [DST_W-1:0]       dst_out,
    input  logic [DATA_W-1:0]      data_out,
    input  logic                   emptyp,
    output logic                   readp,
    output logic [NUM_PORTS-1:0]   rt_valid,
    input  logic [NUM_PORTS-1:0]   rt_ready,
    output logic [SRC_W-1:0]       rt_src,
    output logic [DST_W-1:0]       rt_dst,
    output logic [DATA_W-1:0]      rt_data,
    output logic                   drop_pulse
`ifdef FIFO_ROUTER_STATS_EN
    ,
    output logic [NUM_PORTS*CNT_W-1:0] stat_sent,
    output logic [CNT_W-1:0]           stat_drop
`endif
);

    localparam int unsigned SEL_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    state_e                 r_state;
    state_e                 w_state_nxt;
    word_t                  r_hold;
    logic [SEL_W-1:0]       w_sel;
    logic                   w_in_range;
    logic                   w_handshake;

    assign w_sel       = r_hold.dst[SEL_W-1:0];
    assign w_in_range  = dst_in_range(dst_out, NUM_PORTS);
    assign w_handshake = (r_state == SEND) && rt_ready[w_sel];

    // State register.
    always_ff @(posedge clk or posedge rstp) begin
        if (rstp) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Capture the word arriving one cycle after the read strobe.
    always_ff @(posedge clk or posedge rstp) begin
        if (rstp) begin
            r_hold <= '0;
        end else if (r_state == WAIT) begin
            r_hold <= '{src: src_out, dst: dst_out, data: data_out};
        end
    end

    // Next state, read strobe, port valid and drop pulse.
    always_comb begin
        w_state_nxt = r_state;
        readp       = 1'b0;
        rt_valid    = '0;
        drop_pulse  = 1'b0;

        case (r_state)
            IDLE: begin
                if (!emptyp) begin
                    readp       = 1'b1;
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (w_in_range) begin
                    w_state_nxt = SEND;
                end else begin
                    drop_pulse  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            SEND: begin
                rt_valid = NUM_PORTS'(1) << w_sel;
                if (w_handshake) begin
                    // Chain straight into the next read to sustain one word per two cycles.
                    if (!emptyp) begin
                        readp       = 1'b1;
                        w_state_nxt = WAIT;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Reset silences every strobe immediately, including the combinational ones.
        if (rstp) begin
            readp      = 1'b0;
            rt_valid   = '0;
            drop_pulse = 1'b0;
        end
    end

    assign rt_src  = r_hold.src;
    assign rt_dst  = r_hold.dst;
    assign rt_data = r_hold.data;

`ifdef FIFO_ROUTER_STATS_EN
    // Per-port delivered-word counters.
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_sent
        logic w_inc;
        assign w_inc = w_handshake && (w_sel == SEL_W'(p));
        router_sat_cnt #(.CNT_W(CNT_W)) u_sent (
            .clk   (clk),
            .rstp  (rstp),
            .inc   (w_inc),
            .count (stat_sent[p*CNT_W +: CNT_W])
        );
    end

    // Dropped-word counter.
    router_sat_cnt #(.CNT_W(CNT_W)) u_drop (
        .clk   (clk),
        .rstp  (rstp),
        .inc   (drop_pulse),
        .count (stat_drop)
    );
`endif

endmodule

// File: tb/tb_fifo_drain_router.sv
// Directed, table-driven bench for fifo_drain_router.
module tb_fifo_drain_router;

    localparam int unsigned NP = 4;
    localparam logic [7:0]  JS = 8'hEE;
    localparam logic [7:0]  JD = 8'hEE;
    localparam logic [31:0] JW = 32'hBADBAD00;
    localparam logic [3:0]  F  = 4'hF;

    typedef struct {
        logic        rst;
        logic        empty;
        logic [3:0]  rdy;
        logic [7:0]  src;
        logic [7:0]  dst;
        logic [31:0] data;
        logic        e_readp;
        logic [3:0]  e_valid;
        logic        e_drop;
        logic        chk_hold;
        logic [7:0]  e_src;
        logic [7:0]  e_dst;
        logic [31:0] e_data;
    } vec_t;

    logic          clk = 1'b0;
    logic          rstp;
    logic [7:0]    src_out, dst_out;
    logic [31:0]   data_out;
    logic          emptyp;
    logic          readp;
    logic [NP-1:0] rt_valid, rt_ready;
    logic [7:0]    rt_src, rt_dst;
    logic [31:0]   rt_data;
    logic          drop_pulse;

    int n_vec = 0;
    int n_err = 0;
    int vidx  = 0;

    always #5 clk = ~clk;

`ifdef FIFO_ROUTER_STATS_EN
    logic [NP*16-1:0] stat_sent;
    logic [15:0]      stat_drop;
    logic [NP*2-1:0]  sat_sent;
    logic [1:0]       sat_drop;
    logic             s_readp, s_drop;
    logic [NP-1:0]    s_valid;
    logic [7:0]       s_src, s_dst;
    logic [31:0]      s_data;
`endif

    fifo_drain_router #(.NUM_PORTS(NP), .CNT_W(16)) dut (
        .clk        (clk),
        .rstp       (rstp),
        .src_out    (src_out),
        .dst_out    (dst_out),
        .data_out   (data_out),
        .emptyp     (emptyp),
        .readp      (readp),
        .rt_valid   (rt_valid),
        .rt_ready   (rt_ready),
        .rt_src     (rt_src),
        .rt_dst     (rt_dst),
        .rt_data    (rt_data),
        .drop_pulse (drop_pulse)
`ifdef FIFO_ROUTER_STATS_EN
        ,
        .stat_sent  (stat_sent),
        .stat_drop  (stat_drop)
`endif
    );

`ifdef FIFO_ROUTER_STATS_EN
    fifo_drain_router #(.NUM_PORTS(NP), .CNT_W(2)) dut_sat (
        .clk        (clk),
        .rstp       (rstp),
        .src_out    (src_out),
        .dst_out    (dst_out),
        .data_out   (data_out),
        .emptyp     (emptyp),
        .readp      (s_readp),
        .rt_valid   (s_valid),
        .rt_ready   (rt_ready),
        .rt_src     (s_src),
        .rt_dst     (s_dst),
        .rt_data    (s_data),
        .drop_pulse (s_drop),
        .stat_sent  (sat_sent),
        .stat_drop  (sat_drop)
    );
`endif

    function automatic vec_t mk(input logic rst, input logic empty, input logic [3:0] rdy,
                                input logic [7:0] src, input logic [7:0] dst, input logic [31:0] data,
                                input logic er, input logic [3:0] ev, input logic ed,
                                input logic ch, input logic [7:0] es, input logic [7:0] edst,
                                input logic [31:0] edata);
        vec_t v;
        v.rst = rst; v.empty = empty; v.rdy = rdy;
        v.src = src; v.dst = dst; v.data = data;
        v.e_readp = er; v.e_valid = ev; v.e_drop = ed;
        v.chk_hold = ch; v.e_src = es; v.e_dst = edst; v.e_data = edata;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        if (got !== exp) begin
            n_err++;
            $display("FAIL v%0d %s: got %h want %h", vidx, nm, got, exp);
        end
    endtask

    // Apply one cycle of inputs at the falling edge and check outputs shortly after.
    task automatic step(input vec_t v);
        @(negedge clk);
        rstp     = v.rst;
        emptyp   = v.empty;
        rt_ready = v.rdy;
        src_out  = v.src;
        dst_out  = v.dst;
        data_out = v.data;
        #1;
        n_vec++;
        chk("readp", 32'(readp), 32'(v.e_readp));
        chk("rt_valid", 32'(rt_valid), 32'(v.e_valid));
        chk("drop_pulse", 32'(drop_pulse), 32'(v.e_drop));
        if (v.chk_hold) begin
            chk("rt_src", 32'(rt_src), 32'(v.e_src));
            chk("rt_dst", 32'(rt_dst), 32'(v.e_dst));
            chk("rt_data", rt_data, v.e_data);
        end
        vidx++;
    endtask

    vec_t tbl[$];

    initial begin
        logic [7:0]  s, d;
        logic [31:0] w;
        logic        last;

        rstp = 1'b1; emptyp = 1'b1; rt_ready = '0;
        src_out = JS; dst_out = JD; data_out = JW;
        repeat (2) @(posedge clk);

        // Reset state.
        tbl.push_back(mk(1, 0, F, JS, JD, JW, 0, 4'b0000, 0, 1, 8'h00, 8'h00, 32'h0));
        // Single word to port 2.
        tbl.push_back(mk(0, 0, F, JS, JD, JW, 1, 4'b0000, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, F, 8'h11, 8'h02, 32'hDEADBEEF, 0, 4'b0000, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, F, JS, JD, JW, 0, 4'b0100, 0, 1, 8'h11, 8'h02, 32'hDEADBEEF));
        tbl.push_back(mk(0, 1, F, JS, JD, JW, 0, 4'b0000, 0, 1, 8'h11, 8'h02, 32'hDEADBEEF));
        // Backpressure on port 1 for five cycles, other ready bits high.
        tbl.push_back(mk(0, 0, F, JS, JD, JW, 1, 4'b0000, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, F, 8'h22, 8'h01, 32'hCAFE0001, 0, 4'b0000, 0, 0, 0, 0, 0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0, 0, 4'b1101, JS, JD, JW, 0, 4'b0010, 0, 1, 8'h22, 8'h01, 32'hCAFE0001));
        tbl.push_back(mk(0, 1, 4'b0010, JS, JD, JW, 0, 4'b0010, 0, 1, 8'h22, 8'h01, 32'hCAFE0001));
        tbl.push_back(mk(0, 1, F, JS, JD, JW, 0, 4'b0000, 0, 0, 0, 0, 0));
        // Out-of-range destination is dropped.
        tbl.push_back(mk(0, 0, F, JS, JD, JW, 1, 4'b0000, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, F, 8'h33, 8'h07, 32'h0BAD0007, 0, 4'b0000, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, F, JS, JD, JW, 0, 4'b0000, 0, 0, 0, 0, 0));

        foreach (tbl[i]) step(tbl[i]);

        // Back-to-back: eight words, ports 0..3 repeating, all ready.
        step(mk(0, 0, F, JS, JD, JW, 1, 4'b0000, 0, 0, 0, 0, 0));
        for (int i = 0; i < 8; i++) begin
            s = 8'(8'h40 + i); d = 8'(i % 4); w = 32'hB2B00000 + 32'(i);
            last = (i == 7);
            step(mk(0, 0, F, s, d, w, 0, 4'b0000, 0, 0, 0, 0, 0));
            step(mk(0, last, F, JS, JD, JW, !last, 4'(1 << (i % 4)), 0, 1, s, d, w));
        end
        step(mk(0, 1, F, JS, JD, JW, 0, 4'b0000, 0, 0, 0, 0, 0));

`ifdef FIFO_ROUTER_STATS_EN
        n_vec++;
        chk("stat_sent0", 32'(stat_sent[0 +: 16]), 32'd2);
        chk("stat_sent1", 32'(stat_sent[16 +: 16]), 32'd3);
        chk("stat_sent2", 32'(stat_sent[32 +: 16]), 32'd3);
        chk("stat_sent3", 32'(stat_sent[48 +: 16]), 32'd2);
        chk("stat_drop", 32'(stat_drop), 32'd1);
        chk("sat_sent1", 32'(sat_sent[2 +: 2]), 32'd3);
`endif

        // Reset pulsed while a word waits on port 0.
        step(mk(0, 0, F, JS, JD, JW, 1, 4'b0000, 0, 0, 0, 0, 0));
        step(mk(0, 0, F, 8'h55, 8'h00, 32'h5A5A0000, 0, 4'b0000, 0, 0, 0, 0, 0));
        step(mk(0, 0, 4'b0000, JS, JD, JW, 0, 4'b0001, 0, 1, 8'h55, 8'h00, 32'h5A5A0000));
        step(mk(1, 0, F, JS, JD, JW, 0, 4'b0000, 0, 1, 8'h00, 8'h00, 32'h0));
        step(mk(0, 1, F, JS, JD, JW, 0, 4'b0000, 0, 1, 8'h00, 8'h00, 32'h0));
        step(mk(0, 1, F, JS, JD, JW, 0, 4'b0000, 0, 0, 0, 0, 0));

        // Five words to port 0 (saturates a 2-bit counter).
        step(mk(0, 0, F, JS, JD, JW, 1, 4'b0000, 0, 0, 0, 0, 0));
        for (int i = 0; i < 5; i++) begin
            w = 32'h00C0FFEE + 32'(i);
            last = (i == 4);
            step(mk(0, 0, F, 8'h66, 8'h00, w, 0, 4'b0000, 0, 0, 0, 0, 0));
            step(mk(0, last, 4'b0001, JS, JD, JW, !last, 4'b0001, 0, 1, 8'h66, 8'h00, w));
        end
        step(mk(0, 1, F, JS, JD, JW, 0, 4'b0000, 0, 0, 0, 0, 0));

`ifdef FIFO_ROUTER_STATS_EN
        n_vec++;
        chk("stat_sent0_after_rst", 32'(stat_sent[0 +: 16]), 32'd5);
        chk("stat_sent1_after_rst", 32'(stat_sent[16 +: 16]), 32'd0);
        chk("stat_drop_after_rst", 32'(stat_drop), 32'd0);
        chk("sat_sent0", 32'(sat_sent[0 +: 2]), 32'd3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_drain_router.md
FIFO_DRAIN_ROUTER -- requirements
Module: fifo_drain_router

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, number of output ports, legal 2..8.
REQ-002 SHALL have parameter CNT_W, default 16, width of statistics counters.
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rstp  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port src_out  input  8  source tag from upstream FIFO.
REQ-006 SHALL have port dst_out  input  8  destination tag from upstream FIFO.
REQ-007 SHALL have port data_out  input  32  payload from upstream FIFO.
REQ-008 SHALL have port emptyp  input  1  upstream FIFO empty flag.
REQ-009 SHALL have port readp  output  1  read strobe to upstream FIFO.
REQ-010 SHALL have port rt_valid  output  NUM_PORTS  one-hot per-port valid.
REQ-011 SHALL have port rt_ready  input  NUM_PORTS  per-port ready.
REQ-012 SHALL have ports rt_src, rt_dst, rt_data  output  8/8/32  shared held word.
REQ-013 SHALL have port drop_pulse  output  1  one-cycle pulse per dropped word.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, SEND.
REQ-015 SHALL assert readp combinationally in IDLE when emptyp=0 and go to WAIT next cycle; readp SHALL be 0 in WAIT.
REQ-016 SHALL treat upstream data as valid in the cycle after readp=1 (one-cycle read latency) and capture src/dst/data into hold registers in WAIT.
REQ-017 SHALL, in WAIT, go to SEND if dst_out < NUM_PORTS, else pulse drop_pulse for one cycle and go to IDLE.
REQ-018 SHALL, in SEND, drive rt_valid bit dst_hold[SEL_W-1:0] high and all others low; rt_valid SHALL be all-zero in IDLE and WAIT.
REQ-019 SHALL hold rt_src/rt_dst/rt_data stable throughout SEND until handshake.
REQ-020 SHALL complete transfer when rt_valid[i]=1 and rt_ready[i]=1 in the same cycle; rt_ready bits of non-selected ports SHALL be ignored.
REQ-021 SHALL, on handshake with emptyp=0, assert readp in that same cycle and go to WAIT (3-cycle-per-word minimum is IDLE-free: 2 cycles/word back-to-back).
REQ-022 SHALL, on handshake with emptyp=1, go to IDLE.
REQ-023 SHALL never assert readp while emptyp=1.
REQ-024 SHALL never deassert rt_valid before handshake (no timeout, no retraction).

Reset
REQ-025 SHALL, while rstp=1, force state IDLE, readp=0, rt_valid=0, drop_pulse=0, hold registers to 0, counters to 0.
REQ-026 SHALL discard any held or in-flight word when rstp asserts mid-operation; the upstream word read in the reset cycle is lost.
REQ-027 SHALL resume in IDLE on the first rising edge after rstp deasserts.

Configuration
REQ-028 SHALL compile statistics in only when macro FIFO_ROUTER_STATS_EN is defined: outputs stat_sent (NUM_PORTS*CNT_W, per-port delivered count) and stat_drop (CNT_W), each saturating at all-ones.
REQ-029 SHALL, without FIFO_ROUTER_STATS_EN, omit stat_sent/stat_drop ports and all counter logic; routing behaviour SHALL be identical.

Structure
REQ-030 SHALL place state enum, SRC_W=8, DST_W=8, DATA_W=32 in shared package fifo_router_pkg.
REQ-031 SHALL implement each saturating counter as sub-module router_sat_cnt (parameter CNT_W, inputs clk, rstp, inc).

Verification
REQ-032 Single word: src=0x11,dst=0x02,data=0xDEADBEEF, rt_ready=4'b1111 -> readp 1 cycle, rt_valid=4'b0100 two cycles later, one handshake, back to IDLE.
REQ-033 Backpressure: dst=1, rt_ready[1]=0 for 5 cycles -> rt_valid=4'b0010 held 5 cycles with stable rt_data, readp=0 throughout, transfer on 6th.
REQ-034 Drop: dst=0x07 with NUM_PORTS=4 -> no rt_valid, drop_pulse one cycle, stat_drop=1 when FIFO_ROUTER_STATS_EN.
REQ-035 Back-to-back: 8 words dst=0..3 repeating, all ready -> readp on handshake cycles, one word per 2 cycles, stat_sent=2 per port.
REQ-036 Reset mid-SEND: rstp pulsed while rt_valid=4'b0001 -> rt_valid=0 and readp=0 immediately, no stale word after release.
REQ-037 Saturation: CNT_W=2, 5 words to port 0 -> stat_sent[0]=3.
